// File: rtl/adder_tree_csa_pkg.sv
// Shared elaboration-time helpers for the carry-save adder tree.
// StageCount(n) : number of 3:2 levels needed to bring n operands down to 3
// OpCount(n, l) : number of operands entering level l (level 0 = raw inputs)
// OutWidth(w, n): width of the final registered sum
package adder_tree_csa_pkg;

  // One 3:2 level: each full group of three becomes two, leftovers pass.
  function automatic int NextCount(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Levels until exactly three operands remain. Stops at or below 3 so an
  // unsupported n (< 4) cannot spin forever during elaboration.
  function automatic int StageCount(input int n);
    int cnt;
    int lvl;
    cnt = n;
    lvl = 0;
    while (cnt > 3) begin
      cnt = NextCount(cnt);
      lvl++;
    end
    return lvl;
  endfunction

  // Operand count at the input of level lvl. The extra 3->2 level after
  // StageCount() follows the same recurrence, so no special case is needed.
  function automatic int OpCount(input int n, input int lvl);
    int cnt;
    cnt = n;
    for (int i = 0; i < lvl; i++) begin
      cnt = NextCount(cnt);
    end
    return cnt;
  endfunction

  // w + (StageCount + 1 CSA levels) + 1 bit of final carry.
  function automatic int OutWidth(input int w, input int n);
    return w + StageCount(n) + 2;
  endfunction

endpackage

// File: rtl/adder_tree_csa_16_in_if.sv
// Data bus for the adder tree.
// i_data : packed input words, word 0 in the most-significant slice
// o_data : registered unsigned sum
// master : side that drives operands and observes the sum
// slave  : the adder tree itself
interface adder_tree_csa_16_in_if #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 32
);
  import adder_tree_csa_pkg::*;

  localparam int O_DATA_W = OutWidth(I_DATA_W, I_DATA_N);

  logic [0:I_DATA_N-1][I_DATA_W-1:0] i_data;
  logic [O_DATA_W-1:0]               o_data;

  modport master (output i_data, input o_data);
  modport slave  (input i_data, output o_data);
endinterface

// File: rtl/csa_3_2.sv
// Row of W full adders used as a 3:2 compressor.
// a, b, c : W-bit operands
// s       : W+1-bit bitwise sum (top bit always 0)
// cy      : W+1-bit majority, already shifted left by one
module csa_3_2 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W:0]   s,
  output logic [W:0]   cy
);
  assign s  = {1'b0, a ^ b ^ c};
  assign cy = {(a & b) | (a & c) | (b & c), 1'b0};
endmodule

// File: rtl/adder_tree_csa_16_in.sv
// Pipelined carry-save adder tree: sums I_DATA_N unsigned I_DATA_W-bit words.
// Pipeline: input register, one register per 3:2 level, registered final adder.
// Latency is STAGES_N + 1 edges after the input register samples; one new
// vector accepted per clock.
// clk : rising-edge clock
// rst : synchronous active-high reset, clears every pipeline register
// bus : slave side of adder_tree_csa_16_in_if (i_data in, o_data out); its
//       parameters must match this module's parameters
module adder_tree_csa_16_in
  import adder_tree_csa_pkg::*;
#(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 32
) (
  input logic                  clk,
  input logic                  rst,
  adder_tree_csa_16_in_if.slave bus
);

  localparam int STAGES_N = StageCount(I_DATA_N) + 1;
  localparam int O_DATA_W = I_DATA_W + STAGES_N + 1;

  if (I_DATA_N < 4) begin : g_bad_n
    $error("adder_tree_csa_16_in: I_DATA_N must be at least 4");
  end

  // Input sampling register (level-0 operands).
  logic [I_DATA_W-1:0] in_reg [I_DATA_N];

  always_ff @(posedge clk) begin
    for (int k = 0; k < I_DATA_N; k++) begin
      if (rst) in_reg[k] <= '0;
      else     in_reg[k] <= bus.i_data[k];
    end
  end

  // Each level reads the previous level's registers (or in_reg), compresses
  // complete triples, zero-extends leftovers, and registers the result.
  for (genvar gi = 0; gi < STAGES_N; gi++) begin : g_lvl
    localparam int IN_N  = OpCount(I_DATA_N, gi);
    localparam int OUT_N = OpCount(I_DATA_N, gi + 1);
    localparam int IN_W  = I_DATA_W + gi;
    localparam int GRP_N = IN_N / 3;

    logic [IN_W-1:0] lvl_d    [IN_N];
    logic [IN_W:0]   lvl_next [OUT_N];
    logic [IN_W:0]   lvl_reg  [OUT_N];

    for (genvar ki = 0; ki < IN_N; ki++) begin : g_src
      if (gi == 0) begin : g_first
        assign lvl_d[ki] = in_reg[ki];
      end else begin : g_prev
        assign lvl_d[ki] = g_lvl[gi-1].lvl_reg[ki];
      end
    end

    for (genvar ki = 0; ki < GRP_N; ki++) begin : g_csa
      csa_3_2 #(.W(IN_W)) u_csa (
        .a  (lvl_d[3*ki]),
        .b  (lvl_d[3*ki+1]),
        .c  (lvl_d[3*ki+2]),
        .s  (lvl_next[2*ki]),
        .cy (lvl_next[2*ki+1])
      );
    end

    for (genvar ki = 0; ki < IN_N - 3*GRP_N; ki++) begin : g_pass
      assign lvl_next[2*GRP_N + ki] = {1'b0, lvl_d[3*GRP_N + ki]};
    end

    always_ff @(posedge clk) begin
      for (int k = 0; k < OUT_N; k++) begin
        if (rst) lvl_reg[k] <= '0;
        else     lvl_reg[k] <= lvl_next[k];
      end
    end
  end

  // Final carry-propagate add of the two surviving operands; one extra bit
  // of width is enough since the true sum never exceeds N*(2^W-1).
  logic [O_DATA_W-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= O_DATA_W'(g_lvl[STAGES_N-1].lvl_reg[0])
               + O_DATA_W'(g_lvl[STAGES_N-1].lvl_reg[1]);
    end
  end

  assign bus.o_data = sum_reg;

endmodule

// File: tb/tb_adder_tree_csa_16_in.sv
// Testbench for adder_tree_csa_16_in: one N=32 and one N=16 instance (W=3)
// driven in lockstep. Stimulus pushes expected sums into per-instance queues;
// a monitor pops and compares one entry per clock once the pipeline is full.
module tb_adder_tree_csa_16_in;

  localparam int W   = 3;
  localparam int L32 = 9;  // latency for N=32
  localparam int L16 = 7;  // latency for N=16

  typedef logic [0:31][W-1:0] vec32_t;
  typedef logic [0:15][W-1:0] vec16_t;

  logic clk;
  logic rst;

  adder_tree_csa_16_in_if #(.I_DATA_W(W), .I_DATA_N(32)) bus32 ();
  adder_tree_csa_16_in_if #(.I_DATA_W(W), .I_DATA_N(16)) bus16 ();

  adder_tree_csa_16_in #(.I_DATA_W(W), .I_DATA_N(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  adder_tree_csa_16_in #(.I_DATA_W(W), .I_DATA_N(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  logic [31:0] exp32_q [$];
  logic [31:0] exp16_q [$];
  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref32(input vec32_t v);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) s += 32'(v[k]);
    return s;
  endfunction

  function automatic logic [31:0] ref16(input vec16_t v);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s += 32'(v[k]);
    return s;
  endfunction

  // Drive one vector pair for one clock and record what should emerge.
  // A reset edge discards everything still in flight, including the vector
  // sampled on that same edge.
  task automatic step(input vec32_t v32, input logic [31:0] e32,
                      input vec16_t v16, input logic [31:0] e16,
                      input logic r);
    @(negedge clk);
    bus32.i_data = v32;
    bus16.i_data = v16;
    rst          = r;
    @(posedge clk);
    if (r) begin
      foreach (exp32_q[i]) exp32_q[i] = '0;
      foreach (exp16_q[i]) exp16_q[i] = '0;
      exp32_q.push_back('0);
      exp16_q.push_back('0);
    end else begin
      exp32_q.push_back(e32);
      exp16_q.push_back(e16);
    end
  endtask

  // Monitor: output after edge m belongs to the entry pushed at edge m-L.
  initial begin
    logic [31:0] e;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp32_q.size() > L32) begin
        e = exp32_q.pop_front();
        a = 32'(bus32.o_data);
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL sum_n32 cycle %0d: got %0d, expected %0d", cycle, a, e);
        end else begin
          $display("cycle %0d n32 sum %0d ok", cycle, a);
        end
      end
      if (exp16_q.size() > L16) begin
        e = exp16_q.pop_front();
        a = 32'(bus16.o_data);
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL sum_n16 cycle %0d: got %0d, expected %0d", cycle, a, e);
        end else begin
          $display("cycle %0d n16 sum %0d ok", cycle, a);
        end
      end
    end
  end

  initial begin
    vec32_t z32, a32, v32;
    vec16_t z16, a16, v16;
    z32 = '0;
    z16 = '0;
    rst = 1'b1;
    bus32.i_data = '0;
    bus16.i_data = '0;

    // Whatever is in the pipeline before the first reset edge is discarded.
    for (int i = 0; i < L32; i++) exp32_q.push_back('0);
    for (int i = 0; i < L16; i++) exp16_q.push_back('0);

    // Reset for three cycles with zero input, then idle.
    repeat (3) step(z32, 32'd0, z16, 32'd0, 1'b1);
    repeat (3) step(z32, 32'd0, z16, 32'd0, 1'b0);

    // All words at maximum: 32*7 = 224, 16*7 = 112; zeros on either side.
    a32 = '1;
    a16 = '1;
    step(a32, 32'd224, a16, 32'd112, 1'b0);
    repeat (10) step(z32, 32'd0, z16, 32'd0, 1'b0);

    // Only word 0 (most-significant slice) = 5.
    v32 = '0; v32[0] = 3'd5;
    v16 = '0; v16[0] = 3'd5;
    step(v32, 32'd5, v16, 32'd5, 1'b0);
    repeat (10) step(z32, 32'd0, z16, 32'd0, 1'b0);

    // Only the last word = 3.
    v32 = '0; v32[31] = 3'd3;
    v16 = '0; v16[15] = 3'd3;
    step(v32, 32'd3, v16, 32'd3, 1'b0);
    repeat (10) step(z32, 32'd0, z16, 32'd0, 1'b0);

    // Back-to-back random vectors.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 32; k++) v32[k] = 3'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) v16[k] = 3'($urandom_range(0, 7));
      step(v32, ref32(v32), v16, ref16(v16), 1'b0);
    end

    // Nine distinct nonzero sums (1..9) in flight, then a one-cycle reset.
    for (int i = 1; i <= 9; i++) begin
      v32 = '0; v16 = '0;
      v32[0] = 3'((i > 7) ? 7 : i);
      v32[1] = 3'((i > 7) ? i - 7 : 0);
      v16[0] = v32[0];
      v16[1] = v32[1];
      step(v32, 32'(i), v16, 32'(i), 1'b0);
    end
    step(a32, 32'd224, a16, 32'd112, 1'b1);

    // First post-reset vector: all words = 1 -> 32 and 16.
    for (int k = 0; k < 32; k++) v32[k] = 3'd1;
    for (int k = 0; k < 16; k++) v16[k] = 3'd1;
    step(v32, 32'd32, v16, 32'd16, 1'b0);
    repeat (12) step(z32, 32'd0, z16, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
